// File: rtl/ws2812_decoder.sv
// WS2812 serial receiver: recovers 24-bit GRB pixels from the single-wire line,
// tracks frame position, and flags timing and overflow problems.
module ws2812_decoder #(
   parameter  int NUM_PIXELS   = 64,
   parameter  int BIT_THRESH   = 7,
   parameter  int MIN_HIGH     = 2,
   parameter  int MAX_HIGH     = 14,
   parameter  int LATCH_CYCLES = 600,
   localparam int PIX_W        = $clog2(NUM_PIXELS)
) (
   input  logic             clk,
   input  logic             SW,
   input  logic             din,
   output logic             pixel_valid,
   output logic [23:0]      pixel_data,
   output logic [PIX_W-1:0] pixel_index,
   output logic             frame_done,
   output logic [PIX_W:0]   frame_pixels,
   output logic             err_timing,
   output logic             err_overflow
);

   localparam int LCW = $clog2(LATCH_CYCLES + 1);
   localparam int HCW = $clog2(MAX_HIGH + 2);

   localparam logic [LCW-1:0]   LATCH_MAX = LCW'(LATCH_CYCLES);
   localparam logic [LCW-1:0]   LATCH_M1  = LCW'(LATCH_CYCLES - 1);
   localparam logic [LCW-1:0]   LOW_ONE   = LCW'(1);
   localparam logic [HCW-1:0]   H_MIN     = HCW'(MIN_HIGH);
   localparam logic [HCW-1:0]   H_ONE     = HCW'(BIT_THRESH);
   localparam logic [HCW-1:0]   H_MAX     = HCW'(MAX_HIGH);
   localparam logic [HCW-1:0]   H_SAT     = HCW'(MAX_HIGH + 1);
   localparam logic [HCW-1:0]   H_FIRST   = HCW'(1);
   localparam logic [PIX_W:0]   PIX_MAX   = (PIX_W+1)'(NUM_PIXELS);

   typedef enum logic [1:0] {SYNC, LOW, HIGH} state_t;

   state_t           state;
   logic             din_s1;
   logic             din_s2;
   logic [LCW-1:0]   low_cnt;
   logic [HCW-1:0]   high_cnt;
   logic [4:0]       bit_cnt;
   logic [PIX_W:0]   pix_cnt;
   logic [23:0]      shreg;
   logic             clr_pend;

   logic             bit_val;
   logic [23:0]      shifted;
   logic             frame_end;

   assign bit_val   = (high_cnt >= H_ONE);
   assign shifted   = {shreg[22:0], bit_val};
   // Frame end is judged on the saturated count, so a rising edge arriving in
   // that same cycle still closes the frame before the new pulse is timed.
   assign frame_end = (state == LOW) && (low_cnt == LATCH_MAX) &&
                      ((pix_cnt != '0) || (bit_cnt != '0));

   always_ff @(posedge clk or negedge SW) begin
      if (!SW) begin
         state        <= SYNC;
         din_s1       <= 1'b0;
         din_s2       <= 1'b0;
         low_cnt      <= '0;
         high_cnt     <= '0;
         bit_cnt      <= '0;
         pix_cnt      <= '0;
         shreg        <= '0;
         clr_pend     <= 1'b0;
         pixel_valid  <= 1'b0;
         pixel_data   <= '0;
         pixel_index  <= '0;
         frame_done   <= 1'b0;
         frame_pixels <= '0;
         err_timing   <= 1'b0;
         err_overflow <= 1'b0;
      end else begin
         din_s1      <= din;
         din_s2      <= din_s1;
         pixel_valid <= 1'b0;
         frame_done  <= 1'b0;

         case (state)
            SYNC: begin
               if (din_s2) begin
                  low_cnt <= '0;
               end else if (low_cnt == LATCH_M1) begin
                  // Resynchronised: treat as a frame boundary for error clearing.
                  state    <= LOW;
                  low_cnt  <= LATCH_MAX;
                  clr_pend <= 1'b1;
               end else begin
                  low_cnt <= low_cnt + 1'b1;
               end
            end

            LOW: begin
               if (frame_end) begin
                  frame_done   <= 1'b1;
                  frame_pixels <= pix_cnt;
                  pix_cnt      <= '0;
                  bit_cnt      <= '0;
                  clr_pend     <= 1'b1;
                  if (bit_cnt != '0)
                     err_timing <= 1'b1;
               end
               if (din_s2) begin
                  // The edge cycle itself is the first high cycle of the pulse.
                  state    <= HIGH;
                  high_cnt <= H_FIRST;
               end else if (low_cnt != LATCH_MAX) begin
                  low_cnt <= low_cnt + 1'b1;
               end
            end

            HIGH: begin
               if (din_s2) begin
                  if (high_cnt != H_SAT)
                     high_cnt <= high_cnt + 1'b1;
               end else begin
                  state   <= LOW;
                  low_cnt <= LOW_ONE;
                  if (high_cnt > H_MAX) begin
                     err_timing <= 1'b1;
                     bit_cnt    <= '0;
                     state      <= SYNC;
                  end else if (high_cnt >= H_MIN) begin
                     shreg <= shifted;
                     if (clr_pend) begin
                        err_timing   <= 1'b0;
                        err_overflow <= 1'b0;
                        clr_pend     <= 1'b0;
                     end
                     if (bit_cnt == 5'd23) begin
                        bit_cnt <= '0;
                        if (pix_cnt == PIX_MAX) begin
                           err_overflow <= 1'b1;
                        end else begin
                           pixel_valid <= 1'b1;
                           pixel_data  <= shifted;
                           pixel_index <= pix_cnt[PIX_W-1:0];
                           pix_cnt     <= pix_cnt + 1'b1;
                        end
                     end else begin
                        bit_cnt <= bit_cnt + 1'b1;
                     end
                  end
               end
            end

            default: state <= SYNC;
         endcase
      end
   end

endmodule

// File: doc/ws2812_decoder.md
WS2812_DECODER -- requirements
Module: ws2812_decoder

Interface
REQ-001 Parameter NUM_PIXELS, default 64: pixels per frame; PIX_W = clog2(NUM_PIXELS).
REQ-002 Parameter BIT_THRESH, default 7: minimum high-time, in clk cycles, classified as a 1 bit.
REQ-003 Parameter MIN_HIGH, default 2: high pulses shorter than this are glitches.
REQ-004 Parameter MAX_HIGH, default 14: high pulses longer than this are timing errors.
REQ-005 Parameter LATCH_CYCLES, default 600: low time, in clk cycles, that ends a frame (50 us at 12 MHz).
REQ-006 clk  input  1: single system clock; all state on its rising edge.
REQ-007 SW  input  1: reset, asynchronous, active-low.
REQ-008 din  input  1: WS2812 serial line, asynchronous to clk.
REQ-009 pixel_valid  output  1: one-cycle strobe, pixel_data and pixel_index are valid.
REQ-010 pixel_data  output  24: decoded pixel, GRB order, first received bit in bit 23.
REQ-011 pixel_index  output  PIX_W: frame position of pixel_data, 0 for the first pixel.
REQ-012 frame_done  output  1: one-cycle strobe at the end of a frame.
REQ-013 frame_pixels  output  PIX_W+1: whole pixels in the last frame; updated with frame_done.
REQ-014 err_timing  output  1: sticky; a pulse was too long or a frame ended on a partial pixel.
REQ-015 err_overflow  output  1: sticky; more than NUM_PIXELS pixels arrived in one frame.

Function
REQ-016 din SHALL pass through a 2-flop synchronizer; all later logic uses only the synchronized level.
REQ-017 FSM states: SYNC, LOW, HIGH.
REQ-018 SYNC is the state out of reset; it SHALL count consecutive low cycles, restarting the count on any high.
REQ-019 SYNC SHALL move to LOW when the low count reaches LATCH_CYCLES; no bits decode before then.
REQ-020 LOW SHALL count low cycles, saturating at LATCH_CYCLES; a rising edge SHALL enter HIGH with the high counter cleared.
REQ-021 HIGH SHALL count high cycles, saturating at MAX_HIGH+1; a falling edge SHALL classify the pulse and return to LOW with the low counter cleared.
REQ-022 High count < MIN_HIGH: pulse ignored; no bit and no error.
REQ-023 High count in MIN_HIGH..BIT_THRESH-1: bit 0, shifted in.
REQ-024 High count in BIT_THRESH..MAX_HIGH: bit 1, shifted in.
REQ-025 High count > MAX_HIGH: set err_timing, discard partial pixel bits, enter SYNC.
REQ-026 On the 24th accepted bit: pulse pixel_valid for one cycle, the cycle after the falling edge is detected; clear the bit counter; increment the pixel counter.
REQ-027 pixel_data and pixel_index SHALL hold their values until the next pixel_valid.
REQ-028 When pixel count already equals NUM_PIXELS: no pixel_valid; set err_overflow; the counter does not wrap.
REQ-029 Low count reaching LATCH_CYCLES in LOW with pixel count > 0 or bit count > 0: pulse frame_done once and load frame_pixels.
REQ-030 Same frame end with bit count > 0: also set err_timing and discard the partial bits.
REQ-031 After frame_done: clear pixel and bit counters; no further frame_done until new bits arrive.
REQ-032 Error flags SHALL clear on the first accepted bit after frame_done, or on reset.
REQ-033 A rising edge in the same cycle the low count saturates SHALL be treated as the frame end, then as the start of HIGH.

Reset
REQ-034 SW low SHALL immediately force the following, mid-frame included, with partial data discarded:
  - state SYNC; all counters 0
  - synchronizer flops 0
  - pixel_valid, frame_done, err_timing, err_overflow 0
  - pixel_data 0, pixel_index 0, frame_pixels 0
REQ-035 After SW is released, decoding SHALL start only after LATCH_CYCLES of low din.

Verification
REQ-036 Reset, 600 low cycles, then 24 bits of 0xFF0000 (1 bit: 9 high/6 low; 0 bit: 4 high/11 low), then 600 low -> pixel_valid once with pixel_data 0xFF0000, index 0; frame_done, frame_pixels 1; no errors.
REQ-037 64 pixels of value i*0x010101 (i = 0..63), then latch -> 64 strobes in order with matching data and indices; frame_pixels 64.
REQ-038 65 pixels, then latch -> 64 strobes; err_overflow 1; frame_pixels 64.
REQ-039 20-cycle high pulse mid-pixel -> err_timing 1; no pixel_valid; nothing decodes until 600 low cycles; the next good pixel decodes and clears err_timing.
REQ-040 1-cycle glitches between bits -> decoded data unchanged; no error.
REQ-041 SW pulled low after 12 bits, then released -> outputs 0 at once; 12 bits then latch yields no frame_done until a full latch gap precedes new data.
